// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Sole owner of the single-port 8-bit (3:3:2) framebuffer RAM, running in
//   the vgaclk domain. It shares the RAM between the display prefetch path
//   (raster-order reads into a small pixel FIFO) and a CPU write port.
//
//   Optional feature macro: VGA_FB_STATS_EN (adds underrun_cnt and
//   cpu_wait_max status outputs).
//
// Ports
//   vgaclk        pixel clock, all logic on posedge
//   rst           asynchronous active-low reset
//   frame_start   one-cycle pulse before the first active pixel of a frame
//   pix_req       display consumes the FIFO head this cycle
//   pix_valid     FIFO non-empty
//   pix_red/green/blue  head pixel, zero when the FIFO is empty
//   underrun      sticky: pix_req seen while the FIFO was empty
//   cpu_req/addr/data   CPU write request, held until cpu_gnt
//   cpu_gnt       one-cycle pulse, write issued this cycle
//   mem_addr/re/we/wdata  RAM command (combinational from arbitration)
//   mem_rdata     RAM read data, valid the cycle after mem_re
//   underrun_cnt  (VGA_FB_STATS_EN) saturating count of underrun cycles
//   cpu_wait_max  (VGA_FB_STATS_EN) longest CPU stall run, saturating

module vga_fb_arbiter #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LOW_WATER  = 2
) (
    input  logic              vgaclk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_req,
    output logic              pix_valid,
    output logic [2:0]        pix_red,
    output logic [2:0]        pix_green,
    output logic [1:0]        pix_blue,
    output logic              underrun,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_data,
    output logic              cpu_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
`ifdef VGA_FB_STATS_EN
    ,
    output logic [15:0]       underrun_cnt,
    output logic [7:0]        cpu_wait_max
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              inflight_q, inflight_d;
    logic              underrun_q, underrun_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [7:0]        fifo_q [FIFO_DEPTH];

    logic [CNT_W-1:0]  credit;
    logic              issue_rd;
    logic              issue_wr;
    logic              push;
    logic              pop;
    logic              empty;
    logic [7:0]        head;

    assign empty  = (count_q == '0);
    assign credit = count_q + CNT_W'(inflight_q);
    assign head   = fifo_q[rd_ptr_q];

    // A read returning during frame_start belongs to the old frame: drop it.
    assign push = inflight_q && !frame_start;
    assign pop  = pix_req && !empty && !frame_start;

    // ------------------------------------------------------------------
    // Arbitration / FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        issue_rd     = 1'b0;
        issue_wr     = 1'b0;

        if (frame_start) begin
            state_d      = S_ACTIVE;
            fetch_addr_d = '0;
        end else begin
            unique case (state_q)
                S_ACTIVE: begin
                    if (credit <= CNT_W'(LOW_WATER)) begin
                        issue_rd = 1'b1;
                    end else if (cpu_req) begin
                        issue_wr = 1'b1;
                    end else if (credit < CNT_W'(FIFO_DEPTH)) begin
                        issue_rd = 1'b1;
                    end
                end
                default: begin
                    issue_wr = cpu_req;
                end
            endcase

            if (issue_rd) begin
                fetch_addr_d = fetch_addr_q + 1'b1;
                if (fetch_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end
            end
        end

        // The RAM command is combinational from cpu_req, so hold it quiet
        // while reset is asserted.
        if (!rst) begin
            issue_rd = 1'b0;
            issue_wr = 1'b0;
        end
    end

    assign inflight_d = issue_rd;

    always_comb begin
        mem_re    = issue_rd;
        mem_we    = issue_wr;
        cpu_gnt   = issue_wr;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue_wr) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_data;
        end else if (issue_rd) begin
            mem_addr = fetch_addr_q;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointer / count / underrun next state
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        underrun_d = underrun_q;

        if (frame_start) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            underrun_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (pix_req && empty) begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            fetch_addr_q <= '0;
            inflight_q   <= 1'b0;
            underrun_q   <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            inflight_q   <= inflight_d;
            underrun_q   <= underrun_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage needs no reset: every read of it is qualified by count_q.
    always_ff @(posedge vgaclk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_rdata;
        end
    end

    assign pix_valid = !empty;
    assign pix_red   = empty ? 3'b000 : head[7:5];
    assign pix_green = empty ? 3'b000 : head[4:2];
    assign pix_blue  = empty ? 2'b00  : head[1:0];
    assign underrun  = underrun_q;

`ifdef VGA_FB_STATS_EN
    // ------------------------------------------------------------------
    // Optional status counters
    // ------------------------------------------------------------------
    logic [15:0] ucnt_q, ucnt_d;
    logic [7:0]  wait_cur_q, wait_cur_d;
    logic [7:0]  wait_max_q, wait_max_d;

    always_comb begin
        ucnt_d     = ucnt_q;
        wait_cur_d = '0;
        wait_max_d = wait_max_q;

        if (pix_req && empty && !frame_start && (ucnt_q != '1)) begin
            ucnt_d = ucnt_q + 1'b1;
        end

        if (cpu_req && !cpu_gnt) begin
            wait_cur_d = (wait_cur_q == '1) ? wait_cur_q : wait_cur_q + 1'b1;
        end
        if (wait_cur_d > wait_max_q) begin
            wait_max_d = wait_cur_d;
        end
    end

    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            ucnt_q     <= '0;
            wait_cur_q <= '0;
            wait_max_q <= '0;
        end else begin
            ucnt_q     <= ucnt_d;
            wait_cur_q <= wait_cur_d;
            wait_max_q <= wait_max_d;
        end
    end

    assign underrun_cnt = ucnt_q;
    assign cpu_wait_max = wait_max_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter (8x8 frame, 8-entry FIFO, LOW_WATER 2).
// A behavioural RAM preloaded with data[a] = a[7:0] answers reads one cycle
// later. Expected pixels and expected CPU grants are queued by the stimulus
// and consumed by a negedge monitor; cycle-exact arbitration points are
// checked inline.

module tb_vga_fb_arbiter;

    localparam int unsigned AW = 19;

    logic          vgaclk;
    logic          rst;
    logic          frame_start;
    logic          pix_req;
    logic          pix_valid;
    logic [2:0]    pix_red;
    logic [2:0]    pix_green;
    logic [1:0]    pix_blue;
    logic          underrun;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_data;
    logic          cpu_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [8:0]      exp_pix [$];
    logic [AW+7:0]   exp_gnt [$];
    logic [7:0]      ram [int unsigned];

    vga_fb_arbiter #(
        .H_ACTIVE   (8),
        .V_ACTIVE   (8),
        .ADDR_W     (AW),
        .FIFO_DEPTH (8),
        .LOW_WATER  (2)
    ) dut (
        .vgaclk      (vgaclk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_req     (pix_req),
        .pix_valid   (pix_valid),
        .pix_red     (pix_red),
        .pix_green   (pix_green),
        .pix_blue    (pix_blue),
        .underrun    (underrun),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_gnt     (cpu_gnt),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial begin
        vgaclk = 1'b0;
        forever #5 vgaclk = ~vgaclk;
    end

    // Framebuffer RAM model: unwritten locations read back a[7:0].
    always @(posedge vgaclk) begin
        if (mem_we) begin
            ram[int'(mem_addr)] = mem_wdata;
        end
        if (mem_re) begin
            if (ram.exists(int'(mem_addr))) begin
                mem_rdata <= ram[int'(mem_addr)];
            end else begin
                mem_rdata <= mem_addr[7:0];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge vgaclk) begin
        if (rst) begin
            check("re_we_exclusive", {31'd0, mem_re & mem_we}, 32'd0);
            if (pix_req) begin
                if (exp_pix.size() == 0) begin
                    check("pix_unexpected", 32'(exp_pix.size()), 32'd1);
                end else begin
                    check("pixel", {23'd0, pix_valid, pix_red, pix_green, pix_blue},
                          {23'd0, exp_pix.pop_front()});
                end
            end
            if (cpu_gnt) begin
                if (exp_gnt.size() == 0) begin
                    check("gnt_unexpected", 32'(exp_gnt.size()), 32'd1);
                end else begin
                    check("cpu_write", {3'd0, mem_we, mem_re, mem_addr, mem_wdata},
                          {3'd0, 1'b1, 1'b0, exp_gnt.pop_front()});
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge vgaclk);
        #1;
    endtask

    function automatic logic [8:0] pix_exp(input int unsigned a);
        logic [7:0] v;
        v = 8'(a);
        if (a == 5) v = 8'h3C;
        return {1'b1, v};
    endfunction

    initial begin
        rst         = 1'b0;
        frame_start = 1'b0;
        pix_req     = 1'b0;
        cpu_req     = 1'b1;
        cpu_addr    = 19'h00042;
        cpu_data    = 8'h77;

        // Reset: everything quiet even with a pending CPU request.
        repeat (3) @(posedge vgaclk);
        @(negedge vgaclk);
        check("rst_outputs",
              {24'd0, pix_valid, |pix_red, |pix_green, |pix_blue, underrun, cpu_gnt, mem_re, mem_we},
              32'd0);
        check("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        cpu_req = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // Fill.
        frame_start = 1'b1;
        @(negedge vgaclk);
        check("fs_no_op", {30'd0, mem_re, mem_we}, 32'd0);
        next_cycle();
        frame_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge vgaclk);
            check("fill_re", {31'd0, mem_re}, 32'd1);
            check("fill_addr", {13'd0, mem_addr}, i);
            next_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge vgaclk);
            check("fill_full_idle", {31'd0, mem_re}, 32'd0);
            next_cycle();
        end
        @(negedge vgaclk);
        check("fill_head", {23'd0, pix_valid, pix_red, pix_green, pix_blue}, 32'h100);

        // Stream 20 pixels.
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            pix_req = 1'b1;
            exp_pix.push_back({1'b1, 8'(i)});
        end
        next_cycle();
        pix_req = 1'b0;
        @(negedge vgaclk);
        check("stream_underrun", {31'd0, underrun}, 32'd0);

        // Refill, then a CPU write with the FIFO full.
        repeat (10) next_cycle();
        cpu_req  = 1'b1;
        cpu_addr = 19'h00100;
        cpu_data = 8'hA5;
        exp_gnt.push_back({19'h00100, 8'hA5});
        @(negedge vgaclk);
        check("full_cpu_gnt", {30'd0, cpu_gnt, mem_re}, 32'd2);
        next_cycle();
        cpu_req = 1'b0;
        repeat (2) next_cycle();

        // Mid-frame restart with a read in flight, then urgency vs CPU.
        pix_req = 1'b1;                              // pop pixel 20
        exp_pix.push_back(9'h114);
        next_cycle();
        pix_req = 1'b0;
        @(negedge vgaclk);
        check("refetch_re", {31'd0, mem_re}, 32'd1);
        check("refetch_addr", {13'd0, mem_addr}, 32'd28);
        next_cycle();
        frame_start = 1'b1;
        cpu_req     = 1'b1;
        cpu_addr    = 19'h00005;
        cpu_data    = 8'h3C;
        exp_gnt.push_back({19'h00005, 8'h3C});
        @(negedge vgaclk);
        check("restart_no_op", {29'd0, mem_re, mem_we, cpu_gnt}, 32'd0);
        next_cycle();
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge vgaclk);
            check("urgent_re_gnt", {30'd0, mem_re, cpu_gnt}, 32'd2);
            check("urgent_addr", {13'd0, mem_addr}, i);
            check("restart_valid", {31'd0, pix_valid}, (i == 2) ? 32'd1 : 32'd0);
            next_cycle();
        end
        @(negedge vgaclk);
        check("urgent_release_gnt", {30'd0, mem_re, cpu_gnt}, 32'd1);
        next_cycle();
        cpu_req = 1'b0;

        // Consume the whole frame; pixel 5 carries the CPU write.
        for (int i = 0; i < 64; i++) begin
            next_cycle();
            pix_req = 1'b1;
            exp_pix.push_back(pix_exp(i));
        end
        next_cycle();
        pix_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge vgaclk);
            check("done_no_fetch", {30'd0, mem_re, pix_valid}, 32'd0);
            next_cycle();
        end

        // Underrun in DONE.
        pix_req = 1'b1;
        exp_pix.push_back(9'h000);
        next_cycle();
        pix_req = 1'b0;
        @(negedge vgaclk);
        check("underrun_set", {31'd0, underrun}, 32'd1);
        next_cycle();
        @(negedge vgaclk);
        check("underrun_sticky", {31'd0, underrun}, 32'd1);

        // CPU write served immediately in DONE.
        next_cycle();
        cpu_req  = 1'b1;
        cpu_addr = 19'h7FFFF;
        cpu_data = 8'hFF;
        exp_gnt.push_back({19'h7FFFF, 8'hFF});
        @(negedge vgaclk);
        check("done_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
        next_cycle();
        cpu_req = 1'b0;

        // New frame clears underrun and restarts fetch at 0.
        frame_start = 1'b1;
        @(negedge vgaclk);
        check("fs2_no_op", {30'd0, mem_re, cpu_gnt}, 32'd0);
        next_cycle();
        frame_start = 1'b0;
        @(negedge vgaclk);
        check("underrun_cleared", {31'd0, underrun}, 32'd0);
        check("fs2_first_read", {12'd0, mem_re, mem_addr}, {12'd0, 1'b1, 19'd0});
        next_cycle();

        check("pix_queue_drained", 32'(exp_pix.size()), 32'd0);
        check("gnt_queue_drained", 32'(exp_gnt.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
